// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants.
// Used by the fetch unit and its prefetch queue.
package cpu_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [INST_W-1:0] NOP      = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x fetch_entry_t, show-ahead head.
// Synchronous flush wins over a push in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy update; flush empties the queue
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage, contents only meaningful while counted
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front end: PC, inst_mem reads, prefetch queue, decode handoff.
// Optional IF_PERF_CNT_EN adds handshake and flush counters.
module inst_fetch_unit #(
  parameter int                ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                INST_W   = cpu_pkg::INST_W,
  parameter int                IMEM_AW  = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INST_W-1:0]  imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [INST_W-1:0]  dec_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  cpu_pkg::fetch_state_e state_q;
  cpu_pkg::fetch_state_e state_d;
  cpu_pkg::fetch_entry_t head;
  cpu_pkg::fetch_entry_t last_q;
  cpu_pkg::fetch_entry_t push_data;

  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic [ADDR_W-1:0] infl_pc_q;
  logic              inflight_q;
  logic [CW-1:0]     count;
  logic [CW:0]       used;
  logic              full;
  logic              empty;
  logic              issue;
  logic              push;
  logic              pop;
  logic              unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc[1:0];

  // Credit: queued entries plus the outstanding read reserve slots
  assign used = {1'b0, count} + (CW+1)'(inflight_q);

  assign push_data = '{pc: infl_pc_q, inst: imem_rdata};

  assign dec_valid = !empty && !rst;
  assign pop       = dec_valid && dec_ready;
  assign dec_pc    = dec_valid ? head.pc   : last_q.pc;
  assign dec_inst  = dec_valid ? head.inst : last_q.inst;

  assign imem_en   = issue;
  assign imem_addr = rst ? '0 : fetch_pc_q[IMEM_AW+1:2];

  // Control FSM: next state, kill of returns, issue and next PC
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    issue      = 1'b0;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      cpu_pkg::ST_RUN:   push = inflight_q;
      cpu_pkg::ST_FLUSH: push = 1'b0;
      default:           push = 1'b0;
    endcase
    if (!rst && !redirect_valid && !full && (used < DEPTH_C)) begin
      issue = 1'b1;
    end
    if (redirect_valid) begin
      state_d    = cpu_pkg::ST_FLUSH;
      fetch_pc_d = {redirect_pc[ADDR_W-1:2], 2'b00};
    end else begin
      state_d = cpu_pkg::ST_RUN;
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  // Architectural fetch state and last-handed-off entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= cpu_pkg::ST_RUN;
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      infl_pc_q  <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue)     infl_pc_q <= fetch_pc_q;
      if (dec_valid) last_q    <= head;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_o     (head),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] flushed;

  // A handoff in the redirect cycle is not counted as flushed
  assign flushed = 32'(count) - 32'(pop) + 32'(inflight_q);

  // Handshake and flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)            fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect_valid) flush_cnt_q <= flush_cnt_q + flushed;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit.
// Vector table, directed corner sequences, random scoreboard.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        dec_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;

  logic        w_imem_en;
  logic [9:0]  w_imem_addr;
  logic [31:0] w_imem_rdata = '0;
  logic        w_dec_valid;
  logic [31:0] w_dec_pc;
  logic [31:0] w_dec_inst;

`ifdef IF_PERF_CNT_EN
  logic [31:0] pf_fetch, pf_flush, w_pf_fetch, w_pf_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;

  inst_fetch_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_pc        (dec_pc),
    .dec_inst      (dec_inst)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(pf_fetch),
    .perf_flush_cnt(pf_flush)
`endif
  );

  inst_fetch_unit #(
    .RESET_PC(32'hFFFF_FFFC)
  ) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (w_imem_en),
    .imem_addr     (w_imem_addr),
    .imem_rdata    (w_imem_rdata),
    .redirect_valid(1'b0),
    .redirect_pc   (32'h0),
    .dec_valid     (w_dec_valid),
    .dec_ready     (1'b1),
    .dec_pc        (w_dec_pc),
    .dec_inst      (w_dec_inst)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(w_pf_fetch),
    .perf_flush_cnt(w_pf_flush)
`endif
  );

  // inst_mem model: word i holds i, data one cycle after request
  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= {22'h0, imem_addr};
    if (w_imem_en) w_imem_rdata <= {22'h0, w_imem_addr};
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        en;
    logic [9:0]  addr;
    logic        dv;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  vec_t tbl[25];

  function automatic vec_t mk(
    input logic r, input logic rd, input logic rv, input logic [31:0] rpc,
    input logic en, input logic [9:0] a, input logic dv,
    input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v.rst = r; v.rdy = rd; v.rv = rv; v.rpc = rpc;
    v.en = en; v.addr = a; v.dv = dv; v.pc = pc; v.inst = inst;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then settle to the falling edge
  task automatic cyc(input logic r, input logic rd, input logic rv,
                     input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst = r;
    dec_ready = rd;
    redirect_valid = rv;
    redirect_pc = rpc;
    @(negedge clk);
  endtask

  logic [31:0] exp_pc, last_pc, last_inst;
  int blank, idle, hs;
  logic want_valid;

  initial begin
    // rst, rdy, rv, rpc, en, addr, dv, pc, inst
    tbl[0]  = mk(H, H, L, 32'h0,   L, 10'h0,  L, 32'h0,  32'h0);
    tbl[1]  = mk(L, H, L, 32'h0,   H, 10'h0,  L, 32'h0,  32'h0);
    tbl[2]  = mk(L, H, L, 32'h0,   H, 10'h1,  L, 32'h0,  32'h0);
    tbl[3]  = mk(L, H, L, 32'h0,   H, 10'h2,  H, 32'h0,  32'h0);
    tbl[4]  = mk(L, H, L, 32'h0,   H, 10'h3,  H, 32'h4,  32'h1);
    tbl[5]  = mk(L, L, L, 32'h0,   H, 10'h4,  H, 32'h8,  32'h2);
    tbl[6]  = mk(L, L, L, 32'h0,   H, 10'h5,  H, 32'h8,  32'h2);
    tbl[7]  = mk(L, L, L, 32'h0,   L, 10'h6,  H, 32'h8,  32'h2);
    tbl[8]  = mk(L, L, L, 32'h0,   L, 10'h6,  H, 32'h8,  32'h2);
    tbl[9]  = mk(L, H, L, 32'h0,   L, 10'h6,  H, 32'h8,  32'h2);
    tbl[10] = mk(L, H, L, 32'h0,   H, 10'h6,  H, 32'hC,  32'h3);
    tbl[11] = mk(L, H, L, 32'h0,   H, 10'h7,  H, 32'h10, 32'h4);
    tbl[12] = mk(L, H, H, 32'h40,  L, 10'h8,  H, 32'h14, 32'h5);
    tbl[13] = mk(L, H, L, 32'h0,   H, 10'h10, L, 32'h14, 32'h5);
    tbl[14] = mk(L, H, L, 32'h0,   H, 10'h11, L, 32'h14, 32'h5);
    tbl[15] = mk(L, H, L, 32'h0,   H, 10'h12, H, 32'h40, 32'h10);
    tbl[16] = mk(L, H, H, 32'h103, L, 10'h13, H, 32'h44, 32'h11);
    tbl[17] = mk(L, H, H, 32'h80,  L, 10'h40, L, 32'h44, 32'h11);
    tbl[18] = mk(L, H, L, 32'h0,   H, 10'h20, L, 32'h44, 32'h11);
    tbl[19] = mk(L, H, L, 32'h0,   H, 10'h21, L, 32'h44, 32'h11);
    tbl[20] = mk(L, H, L, 32'h0,   H, 10'h22, H, 32'h80, 32'h20);
    tbl[21] = mk(H, H, L, 32'h0,   L, 10'h0,  L, 32'h80, 32'h20);
    tbl[22] = mk(L, H, L, 32'h0,   H, 10'h0,  L, 32'h0,  32'h0);
    tbl[23] = mk(L, H, L, 32'h0,   H, 10'h1,  L, 32'h0,  32'h0);
    tbl[24] = mk(L, H, L, 32'h0,   H, 10'h2,  H, 32'h0,  32'h0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("v%0d_en", i),   imem_en,   tbl[i].en);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_dv", i),   dec_valid, tbl[i].dv);
      chk($sformatf("v%0d_pc", i),   dec_pc,    tbl[i].pc);
      chk($sformatf("v%0d_inst", i), dec_inst,  tbl[i].inst);
      if (i == 3) begin
        chk("wrap_dv0",   w_dec_valid, 1);
        chk("wrap_pc0",   w_dec_pc,    32'hFFFF_FFFC);
        chk("wrap_inst0", w_dec_inst,  32'h3FF);
      end
      if (i == 4) begin
        chk("wrap_dv1",   w_dec_valid, 1);
        chk("wrap_pc1",   w_dec_pc,    32'h0);
        chk("wrap_inst1", w_dec_inst,  32'h0);
      end
    end

    // Redirect with 3 queued + 1 inflight
    cyc(H, L, L, 0);
    cyc(H, L, L, 0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_rst", pf_fetch, 0);
    chk("perf_flush_rst", pf_flush, 0);
`endif
    repeat (4) cyc(L, L, L, 0);
    cyc(L, L, H, 32'h40);
    chk("s3_dv_T",  dec_valid, 1);
    chk("s3_pc_T",  dec_pc,    32'h0);
    chk("s3_en_T",  imem_en,   0);
    cyc(L, L, L, 0);
    chk("s3_dv_T1",   dec_valid, 0);
    chk("s3_en_T1",   imem_en,   1);
    chk("s3_addr_T1", imem_addr, 10'h10);
`ifdef IF_PERF_CNT_EN
    chk("perf_flush_s3", pf_flush, 4);
`endif
    cyc(L, L, L, 0);
    chk("s3_dv_T2", dec_valid, 0);
    cyc(L, L, L, 0);
    chk("s3_dv_T3",   dec_valid, 1);
    chk("s3_pc_T3",   dec_pc,    32'h40);
    chk("s3_inst_T3", dec_inst,  32'h10);

    // Fill the queue, then redirect alongside a handoff
    repeat (4) cyc(L, L, L, 0);
    chk("s4_full_en", imem_en, 0);
    cyc(L, H, H, 32'h200);
    chk("s4_hs_dv", dec_valid, 1);
    chk("s4_hs_pc", dec_pc,    32'h40);
    cyc(L, H, L, 0);
    chk("s4_dv_T1", dec_valid, 0);
    cyc(L, H, L, 0);
    chk("s4_dv_T2", dec_valid, 0);
    cyc(L, H, L, 0);
    chk("s4_pc_T3", dec_pc,   32'h200);
    chk("s4_in_T3", dec_inst, 32'h80);

    // Reset pulse with a full queue
    repeat (6) cyc(L, L, L, 0);
    chk("s6_full_dv", dec_valid, 1);
    cyc(H, L, L, 0);
    cyc(H, L, L, 0);
    chk("s6_rst_dv", dec_valid, 0);
    chk("s6_rst_en", imem_en,   0);
    cyc(L, H, L, 0);
    chk("s6_dv_R",   dec_valid, 0);
    chk("s6_en_R",   imem_en,   1);
    chk("s6_addr_R", imem_addr, 10'h0);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch_s6", pf_fetch, 0);
    chk("perf_flush_s6", pf_flush, 0);
`endif
    cyc(L, H, L, 0);
    cyc(L, H, L, 0);
    chk("s6_pc_R2", dec_pc,    32'h0);
    chk("s6_dv_R2", dec_valid, 1);

    // Random traffic against a transaction-level PC stream model
    cyc(H, L, L, 0);
    cyc(H, L, L, 0);
    exp_pc = 0;
    last_pc = 0;
    last_inst = 0;
    blank = 0;
    idle = 0;
    hs = 0;
    want_valid = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      dec_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(0, 3));
      @(negedge clk);
      if (blank > 0) begin
        chk("rnd_blank", dec_valid, 0);
        blank--;
        if (blank == 0) want_valid = 1'b1;
      end else if (want_valid) begin
        chk("rnd_T3_valid", dec_valid, 1);
        want_valid = 1'b0;
      end
      if (redirect_valid) chk("rnd_no_issue", imem_en, 0);
      if (dec_valid) begin
        idle = 0;
        last_pc = dec_pc;
        last_inst = dec_inst;
        if (dec_ready) begin
          chk("rnd_pc", dec_pc, exp_pc);
          chk("rnd_inst", dec_inst, {22'h0, exp_pc[11:2]});
          exp_pc = exp_pc + 32'd4;
          hs++;
        end
      end else begin
        chk("rnd_hold_pc", dec_pc, last_pc);
        chk("rnd_hold_inst", dec_inst, last_inst);
        if (blank == 0 && !redirect_valid) idle++;
        if (idle == 5) begin
          n_chk++;
          n_fail++;
          $display("FAIL rnd_stall: dec_valid low 5 cycles, required high");
        end
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        blank = 2;
        want_valid = 1'b0;
        idle = 0;
      end
    end
    if (hs < 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL rnd_hs_count: got %0d required >= 500", hs);
    end
`ifdef IF_PERF_CNT_EN
    @(posedge clk);
    #1;
    chk("perf_fetch_rnd", pf_fetch, 32'(hs));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
